// File: rtl/sram_bus_pkg.sv
// Shared types and constants for the three-strobe SRAM bus master.
// Both the master and anything that talks to it import this package.
package sram_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      LATCH_ADR,
      LATCH_DAT,
      COMMIT,
      RESP
   } state_t;

   typedef enum logic [1:0] {
      READ,
      WRITE,
      INIT
   } op_t;

   localparam int SRAM_ADX_W = 11;
   localparam int OP_LATENCY = 5;

endpackage

// File: rtl/sram_bus_master.sv
// Turns a one-word read, write or preload request into the fixed
// SETUP / Clock1 / Clock2 / Clock3 strobe sequence the SRAM expects.
module sram_bus_master
   import sram_bus_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic                  Clock,
   input  logic                  RST,
   input  logic                  Req,
   input  logic                  We,
   input  logic                  Init,
   input  logic [ADDR_W-1:0]     Adx,
   input  logic [DATA_W-1:0]     WData,
   output logic [DATA_W-1:0]     RData,
   output logic                  Ready,
   output logic                  Done,
   output logic [SRAM_ADX_W-1:0] SramAdx,
   inout  tri   [DATA_W-1:0]     SramData,
   output logic                  SramOE,
   output logic                  SramRNW,
   output logic                  SramClk1,
   output logic                  SramClk2,
   output logic                  SramClk3,
   output logic                  SramRst
);

   state_t              state;
   op_t                 op;
   logic [DATA_W-1:0]   wdata_q;
   logic                drive;

   // The data driver is derived from the registered bus controls, so it can
   // never be enabled while the SRAM has its own output enabled.
   assign drive    = !SramRNW && SramOE;
   assign SramData = drive ? wdata_q : 'z;

   // Every output is set one edge ahead so it is registered for the state
   // being entered; strobes follow their address/data by at least a cycle.
   always_ff @(posedge Clock) begin
      if (!RST) begin
         state    <= IDLE;
         op       <= READ;
         wdata_q  <= '0;
         RData    <= '0;
         Ready    <= 1'b1;
         Done     <= 1'b0;
         SramAdx  <= '0;
         SramOE   <= 1'b1;
         SramRNW  <= 1'b1;
         SramClk1 <= 1'b0;
         SramClk2 <= 1'b0;
         SramClk3 <= 1'b0;
         SramRst  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (Init) begin
                  op      <= INIT;
                  SramRst <= 1'b0;
                  Ready   <= 1'b0;
                  state   <= SETUP;
               end else if (Req) begin
                  op      <= We ? WRITE : READ;
                  SramAdx <= SRAM_ADX_W'(Adx);
                  wdata_q <= WData;
                  SramRNW <= !We;
                  Ready   <= 1'b0;
                  state   <= SETUP;
               end
            end
            SETUP: begin
               SramClk1 <= 1'b1;
               state    <= LATCH_ADR;
            end
            LATCH_ADR: begin
               SramClk1 <= 1'b0;
               SramClk2 <= 1'b1;
               state    <= LATCH_DAT;
            end
            LATCH_DAT: begin
               SramClk2 <= 1'b0;
               if (op == READ) begin
                  SramOE <= 1'b0;
               end else begin
                  SramClk3 <= 1'b1;
               end
               state <= COMMIT;
            end
            COMMIT: begin
               // Read data is taken while the SRAM still drives the bus.
               if (op == READ) begin
                  RData <= SramData;
               end
               SramClk3 <= 1'b0;
               SramOE   <= 1'b1;
               SramRNW  <= 1'b1;
               SramRst  <= 1'b1;
               Done     <= 1'b1;
               state    <= RESP;
            end
            RESP: begin
               Done  <= 1'b0;
               Ready <= 1'b1;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_bus_master.sv
// Bench for sram_bus_master: behavioural SRAM on the strobes, an abstract
// memory reference, and a Done-driven scoreboard plus a per-cycle bus monitor.
module tb_sram_bus_master;
   import sram_bus_pkg::*;

   logic        Clock = 1'b0;
   logic        RST   = 1'b0;
   logic        Req   = 1'b0;
   logic        We    = 1'b0;
   logic        Init  = 1'b0;
   logic [9:0]  Adx   = '0;
   logic [31:0] WData = '0;
   wire  [31:0] RData;
   wire         Ready;
   wire         Done;
   wire  [10:0] SramAdx;
   wire  [31:0] SramData;
   wire         SramOE;
   wire         SramRNW;
   wire         SramClk1;
   wire         SramClk2;
   wire         SramClk3;
   wire         SramRst;

   sram_bus_master #(.ADDR_W(10), .DATA_W(32)) dut (
      .Clock(Clock), .RST(RST), .Req(Req), .We(We), .Init(Init),
      .Adx(Adx), .WData(WData), .RData(RData), .Ready(Ready), .Done(Done),
      .SramAdx(SramAdx), .SramData(SramData), .SramOE(SramOE),
      .SramRNW(SramRNW), .SramClk1(SramClk1), .SramClk2(SramClk2),
      .SramClk3(SramClk3), .SramRst(SramRst)
   );

   always #5 Clock = ~Clock;

   // Preload contents of the SRAM, used by the device model and the reference.
   function automatic logic [31:0] preload_val(input logic [9:0] a);
      if (a == 10'd5) return 32'h0000_5A5A;
      if (a == 10'd8) return 32'h0000_00FF;
      return 32'hC0DE_0000 | 32'(a);
   endfunction

   // Behavioural SRAM: MAR on Clock1, MDR on Clock2, commit/preload on Clock3.
   logic [31:0] sram_mem [0:1023];
   logic [9:0]  sram_mar = '0;
   logic [31:0] sram_mdr = '0;

   always @(posedge SramClk1) sram_mar = SramAdx[9:0];
   always @(posedge SramClk2) sram_mdr = SramRNW ? sram_mem[sram_mar] : SramData;

   initial begin
      for (int i = 0; i < 1024; i++) sram_mem[i] = preload_val(10'(i));
      forever begin
         @(posedge SramClk3);
         if (!SramRst) begin
            for (int i = 0; i < 1024; i++) sram_mem[i] = preload_val(10'(i));
         end else if (!SramRNW) begin
            sram_mem[sram_mar] = sram_mdr;
         end
      end
   end

   assign SramData = !SramOE ? sram_mdr : 'z;

   // Abstract reference: what the memory should hold after each accepted op.
   logic [31:0] ref_mem [0:1023];

   typedef struct {
      op_t         op;
      logic [9:0]  adx;
      logic [31:0] data;
      logic [31:0] old;
      int          done_edge;
   } entry_t;

   entry_t      sb_q[$];
   int          edge_num = 0;
   int          idle_from_edge = 0;
   bit          checking = 1'b0;
   bit          active = 1'b0;
   bit          just_reset = 1'b0;
   op_t         cur_op = READ;
   logic [9:0]  cur_adx = '0;
   logic [31:0] cur_data = '0;
   int          cur_k = 0;
   logic [31:0] last_rdata = '0;
   int          errors = 0;
   int          checks = 0;

   always @(posedge Clock) edge_num <= edge_num + 1;

   task automatic check_output(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, actual, expected, edge_num);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic wait_idle();
      while (edge_num < idle_from_edge) step();
   endtask

   // Pins are already set up; the next edge is the accept edge k.
   task automatic accept_op(input op_t op, input logic [9:0] a, input logic [31:0] d);
      entry_t e;
      step();
      e.op        = op;
      e.adx       = a;
      e.data      = d;
      e.old       = ref_mem[a];
      // Done is high in cycle k+5, i.e. right after edge k+4.
      e.done_edge = edge_num + OP_LATENCY - 1;
      case (op)
         INIT:    for (int i = 0; i < 1024; i++) ref_mem[i] = preload_val(10'(i));
         WRITE:   ref_mem[a] = d;
         default: e.data = ref_mem[a];
      endcase
      sb_q.push_back(e);
      active         = 1'b1;
      cur_op         = op;
      cur_adx        = a;
      cur_data       = d;
      cur_k          = edge_num;
      idle_from_edge = edge_num + OP_LATENCY;
   endtask

   task automatic apply_stimulus(input op_t op, input logic [9:0] a,
                                 input logic [31:0] d, input bit hold);
      wait_idle();
      Init  = (op == INIT);
      Req   = (op != INIT);
      We    = (op == WRITE);
      Adx   = a;
      WData = d;
      accept_op(op, a, d);
      if (!hold) begin
         Req  = 1'b0;
         Init = 1'b0;
      end
      // These must be ignored until the next accept.
      We    = 1'($urandom_range(0, 1));
      Adx   = 10'($urandom);
      WData = $urandom;
   endtask

   // Per-cycle bus monitor and Done-driven scoreboard.
   always @(negedge Clock) begin
      if (checking) begin
         int     p;
         bit     in_op;
         logic [7:0] exp_ctl;
         entry_t e;
         p     = edge_num - cur_k;
         in_op = active && (p >= 0) && (p <= 4);
         exp_ctl = {in_op && p == 1,
                    in_op && p == 2,
                    in_op && p == 3 && cur_op != READ,
                    !(in_op && p == 3 && cur_op == READ),
                    !(in_op && p <= 3 && cur_op == WRITE),
                    !(in_op && p <= 3 && cur_op == INIT),
                    in_op && p == 4,
                    edge_num >= idle_from_edge};
         check_output("ctl{clk1,clk2,clk3,oe,rnw,rst,done,ready}",
                      {SramClk1, SramClk2, SramClk3, SramOE, SramRNW, SramRst, Done, Ready},
                      exp_ctl);
         if (in_op && p <= 3 && cur_op != INIT)
            check_output("sram_adx", SramAdx, {1'b0, cur_adx});
         if (in_op && p <= 3 && cur_op == WRITE)
            check_output("sram_wdata", SramData, cur_data);
         if (!SramOE)
            check_output("bus_contention", SramData, sram_mdr);
         if (just_reset) begin
            check_output("reset_rdata", RData, 0);
            check_output("reset_sram_adx", SramAdx, 0);
            just_reset = 1'b0;
         end
         if (Done) begin
            if (sb_q.size() == 0) begin
               check_output("unexpected_done", 1, 0);
            end else begin
               e = sb_q.pop_front();
               check_output("done_timing", 64'(edge_num), 64'(e.done_edge));
               if (e.op == READ) begin
                  check_output("read_data", RData, e.data);
                  last_rdata = e.data;
               end else begin
                  check_output("rdata_hold", RData, last_rdata);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      entry_t e;
      int     r;
      for (int i = 0; i < 1024; i++) ref_mem[i] = preload_val(10'(i));

      // Reset held for a few edges; outputs must sit at reset values.
      RST = 1'b0;
      step();
      checking       = 1'b1;
      just_reset     = 1'b1;
      idle_from_edge = edge_num;
      step();
      step();
      RST = 1'b1;

      // Preload, then read a known preload word.
      apply_stimulus(INIT, 10'd0, 32'd0, 1'b0);
      apply_stimulus(READ, 10'd5, 32'd0, 1'b0);

      // Write at the top address and read it back.
      apply_stimulus(WRITE, 10'h3FF, 32'hDEAD_BEEF, 1'b0);
      apply_stimulus(READ, 10'h3FF, 32'd0, 1'b0);

      // Req held across three back-to-back ops with We toggling.
      apply_stimulus(WRITE, 10'd17, 32'h0BAD_F00D, 1'b1);
      apply_stimulus(READ, 10'd17, 32'd0, 1'b1);
      apply_stimulus(WRITE, 10'd18, 32'h1357_9BDF, 1'b0);

      // Init and Req together: preload first, held read of Adx=8 next.
      wait_idle();
      Init = 1'b1; Req = 1'b1; We = 1'b0; Adx = 10'd8; WData = 32'd0;
      accept_op(INIT, 10'd0, 32'd0);
      Init = 1'b0;
      wait_idle();
      accept_op(READ, 10'd8, 32'd0);
      Req = 1'b0;

      // Reset during LATCH_DAT of a write must leave the old word in place.
      apply_stimulus(WRITE, 10'd2, 32'hCAFE_0002, 1'b0);
      apply_stimulus(WRITE, 10'd2, 32'h1234_5678, 1'b0);
      step();
      step();
      RST = 1'b0;
      step();
      RST = 1'b1;
      e = sb_q.pop_back();
      ref_mem[e.adx] = e.old;
      active         = 1'b0;
      idle_from_edge = edge_num;
      last_rdata     = '0;
      just_reset     = 1'b1;
      apply_stimulus(READ, 10'd2, 32'd0, 1'b0);

      // Randomized traffic over a small address window.
      for (int n = 0; n < 30; n++) begin
         logic [9:0] a;
         a = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
         r = $urandom_range(0, 9);
         if (r == 0)
            apply_stimulus(INIT, 10'd0, 32'd0, 1'($urandom_range(0, 1)));
         else if (r < 5)
            apply_stimulus(WRITE, a, $urandom, 1'($urandom_range(0, 1)));
         else
            apply_stimulus(READ, a, 32'd0, 1'($urandom_range(0, 1)));
      end
      Req  = 1'b0;
      Init = 1'b0;

      wait_idle();
      step();
      step();
      check_output("scoreboard_empty", 64'(sb_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sram_bus_master.md
# sram_bus_master

Single-clock initiator that drives the three-strobe SRAM bus: address/data bus, OE, RNW, Clock1/Clock2/Clock3 phase strobes and the SRAM preload reset. It sits between the processor's load/store path and the SRAM. It converts a one-word read, write or init request into the fixed strobe sequence the SRAM needs, and returns read data with a done pulse.

## Interface
- ADDR_W, 10, word address width; SramAdx bit 10 is always driven 0
- DATA_W, 32, data width; fixed to match the SRAM data bus
- Clock  in  1  system clock; all logic on posedge
- RST  in  1  synchronous, active-low reset
- Req  in  1  request; accepted on a cycle with Req && Ready && !Init
- We  in  1  1 = write, 0 = read; sampled at accept
- Init  in  1  preload request; sampled in IDLE; has priority over Req
- Adx  in  ADDR_W  word address; sampled at accept
- WData  in  DATA_W  write data; sampled at accept
- RData  out  DATA_W  read data; valid while Done=1 and held until next read; reset 0
- Ready  out  1  high only in IDLE; reset value 1
- Done  out  1  one-cycle completion pulse for read, write or init; reset 0
- SramAdx  out  11  {1'b0, Adx}; reset 0
- SramData  inout  32  driven with the write data only while SramRNW=0 and SramOE=1; otherwise high-Z
- SramOE  out  1  active-low SRAM output enable; reset 1
- SramRNW  out  1  read/not-write; reset 1
- SramClk1, SramClk2, SramClk3  out  1 each  SRAM phase strobes; reset 0
- SramRst  out  1  active-low SRAM preload; reset 1

## Operation
- FSM states: IDLE, SETUP, LATCH_ADR, LATCH_DAT, COMMIT, RESP. Op register is READ, WRITE or INIT.
- All Sram* outputs are registered. Strobes are never asserted in the same cycle their qualifying address/data first changes.
- IDLE: Ready=1.
  - If Init: op=INIT, go to SETUP.
  - Else if Req: latch We, Adx, WData, set op, go to SETUP.
- SETUP:
  - Drive SramAdx.
  - WRITE: SramRNW=0 and drive SramData=WData.
  - INIT: SramRst=0.
  - All strobes 0.
- LATCH_ADR: SramClk1=1; the SRAM latches MAR.
- LATCH_DAT: SramClk1=0, SramClk2=1.
  - READ: the SRAM loads MDR from the array.
  - WRITE: the SRAM loads MDR from SramData.
  - INIT: same strobe; the SRAM result is don't-care.
- COMMIT: SramClk2=0.
  - WRITE/INIT: SramClk3=1, which commits the write or performs the preload.
  - READ: SramOE=0 and SramData is released. RData is sampled from SramData at the end of COMMIT.
- RESP:
  - Done=1; all strobes 0; SramOE=1, SramRNW=1, SramRst=1; SramData high-Z.
  - Go to IDLE.
- SramRNW stays 0 from SETUP through COMMIT inclusive. SramRst stays 0 from SETUP through COMMIT for INIT.
- Requests arriving outside IDLE are ignored. Req must stay high until accepted.
- Init and Req together in IDLE: Init is serviced first; a held Req is accepted at the next IDLE.

## Timing
- Accept at edge k gives:
  - SETUP in cycle k+1
  - LATCH_ADR in k+2
  - LATCH_DAT in k+3
  - COMMIT in k+4
  - RESP (Done=1, RData valid for a read) in k+5
  - IDLE/Ready in k+6
- Throughput: one op per 6 cycles; no pipelining.
- Reset mid-operation (RST=0 at any edge): the next cycle is IDLE with every output at its reset value and no further strobe.
  - A write aborted before COMMIT leaves the SRAM unchanged.
  - An aborted op produces no Done.
- Bus contention rule: the master's SramData driver enable is 0 whenever SramOE=0.

## Structure
- Shared package sram_bus_pkg holds:
  - state enum
  - op enum (READ/WRITE/INIT)
  - constants SRAM_ADX_W=11, OP_LATENCY=5
- One module, no sub-modules. The bench pairs it with the existing SRAM model, with each SRAM clock input tied to the matching SramClk strobe.

## Test plan
- Reset, then Init pulse -> SramRst low in k+1..k+4, exactly one SramClk3 pulse, Done at k+5; a following read of Adx=5 returns 32'h0000_5A5A.
- Write Adx=10'h3FF, WData=32'hDEAD_BEEF, then read Adx=10'h3FF -> RData=32'hDEAD_BEEF with Done at k+5; no SramClk3 during the read.
- Req held high with We toggling across three ops -> accepts at k, k+6, k+12; Ready low between accepts; exactly one Done per op.
- Init and Req both high in IDLE -> INIT runs first; the held Req (read Adx=8) is accepted at k+6 and returns 32'h0000_00FF.
- RST low during LATCH_DAT of a write of 32'h1234_5678 to Adx=2 -> next cycle all outputs at reset values, no Done; a subsequent read of Adx=2 returns the prior contents.
- Contention monitor throughout all scenarios -> SramData is never X, and the master never drives while SramOE=0.
